// File: rtl/enc_lane_scheduler_if.sv
// Interface between the encoder master counter and the lane scheduler.
//   con_master_counter : master counter value for the current cycle
//   sch_valid          : masks describe a real cycle
//   sch_parity_mask    : per-lane parity position flags
//   sch_sop_mask       : per-lane start-of-codeword flags
//   sch_eop_mask       : per-lane end-of-codeword flags
//   sch_cw_done_cnt    : completed-codeword count
//   sch_err            : sticky counter-sequencing error
// master = counter side, slave = scheduler side.
interface enc_lane_scheduler_if #(
    parameter int RS_COD_LEN  = 544,
    parameter int ENC_SYM_NUM = 32,
    parameter int CW_CNT_W    = 16
);
    localparam int CNT_W = $clog2(RS_COD_LEN);

    logic [CNT_W-1:0]       con_master_counter;
    logic                   sch_valid;
    logic [ENC_SYM_NUM-1:0] sch_parity_mask;
    logic [ENC_SYM_NUM-1:0] sch_sop_mask;
    logic [ENC_SYM_NUM-1:0] sch_eop_mask;
    logic [CW_CNT_W-1:0]    sch_cw_done_cnt;
    logic                   sch_err;

    modport master (
        output con_master_counter,
        input  sch_valid, sch_parity_mask, sch_sop_mask, sch_eop_mask,
        input  sch_cw_done_cnt, sch_err
    );

    modport slave (
        input  con_master_counter,
        output sch_valid, sch_parity_mask, sch_sop_mask, sch_eop_mask,
        output sch_cw_done_cnt, sch_err
    );
endinterface

// File: rtl/enc_lane_scheduler.sv
// Per-cycle lane classifier for the encoder datapath. Each of the
// ENC_SYM_NUM lanes is tagged as parity / start-of-codeword /
// end-of-codeword from the master counter, so the parity-insertion mux
// and output framer need no position arithmetic of their own.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   sch_if : slave modport of enc_lane_scheduler_if (counter in,
//            registered masks / codeword count / sticky error out)
module enc_lane_scheduler #(
    parameter int RS_COD_LEN  = 544,
    parameter int RS_MSG_LEN  = 514,
    parameter int ENC_SYM_NUM = 32,
    parameter int CW_CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    enc_lane_scheduler_if.slave  sch_if
);
    localparam int CNT_W = $clog2(RS_COD_LEN);
    localparam int PW    = CNT_W + 1;   // lane position width
    localparam int SW    = CNT_W + 2;   // headroom for out-of-range c_prev + lanes

    localparam logic [PW-1:0] COD_LEN_P = PW'(RS_COD_LEN);
    localparam logic [PW-1:0] MSG_LEN_P = PW'(RS_MSG_LEN);
    localparam logic [PW-1:0] LAST_P    = PW'(RS_COD_LEN - 1);
    localparam logic [SW-1:0] COD_LEN_S = SW'(RS_COD_LEN);
    localparam logic [SW-1:0] SYM_S     = SW'(ENC_SYM_NUM);

    logic [CNT_W-1:0]       cnt_in;

    logic                   valid_q,  valid_d;
    logic [ENC_SYM_NUM-1:0] parity_q, parity_d;
    logic [ENC_SYM_NUM-1:0] sop_q,    sop_d;
    logic [ENC_SYM_NUM-1:0] eop_q,    eop_d;
    logic [CW_CNT_W-1:0]    cw_cnt_q, cw_cnt_d;
    logic                   err_q,    err_d;
    logic [CNT_W-1:0]       c_prev_q, c_prev_d;
    logic                   prev_vld_q, prev_vld_d;

    logic [PW-1:0]          pos;
    logic [SW-1:0]          exp_cnt;
    logic                   seq_bad;
    logic                   range_bad;

    assign cnt_in = sch_if.con_master_counter;

    // Lane classification. A single conditional subtract is enough because
    // at most one codeword boundary falls inside one cycle's lanes.
    always_comb begin
        parity_d = '0;
        sop_d    = '0;
        eop_d    = '0;
        pos      = '0;
        for (int j = 0; j < ENC_SYM_NUM; j++) begin
            pos = {1'b0, cnt_in} + PW'(j);
            if (pos >= COD_LEN_P) begin
                pos = pos - COD_LEN_P;
            end
            parity_d[j] = (pos >= MSG_LEN_P);
            sop_d[j]    = (pos == '0);
            eop_d[j]    = (pos == LAST_P);
        end
    end

    // Sequence check. The counter may legally sit at RS_COD_LEN (alias of 0),
    // hence the strict '>' when deciding whether the expected value wraps.
    always_comb begin
        exp_cnt = {2'b00, c_prev_q} + SYM_S;
        if (exp_cnt > COD_LEN_S) begin
            exp_cnt = exp_cnt - COD_LEN_S;
        end
        seq_bad   = prev_vld_q && ({2'b00, cnt_in} != exp_cnt);
        range_bad = ({1'b0, cnt_in} > COD_LEN_P);
    end

    always_comb begin
        valid_d    = 1'b1;
        c_prev_d   = cnt_in;
        prev_vld_d = 1'b1;
        err_d      = err_q | seq_bad | range_bad;
        cw_cnt_d   = cw_cnt_q;
        // Counts the cycle after the end-of-codeword lane is presented.
        if (|eop_q) begin
            cw_cnt_d = cw_cnt_q + CW_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            parity_q   <= '0;
            sop_q      <= '0;
            eop_q      <= '0;
            cw_cnt_q   <= '0;
            err_q      <= 1'b0;
            c_prev_q   <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            parity_q   <= parity_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            cw_cnt_q   <= cw_cnt_d;
            err_q      <= err_d;
            c_prev_q   <= c_prev_d;
            prev_vld_q <= prev_vld_d;
        end
    end

    assign sch_if.sch_valid       = valid_q;
    assign sch_if.sch_parity_mask = parity_q;
    assign sch_if.sch_sop_mask    = sop_q;
    assign sch_if.sch_eop_mask    = eop_q;
    assign sch_if.sch_cw_done_cnt = cw_cnt_q;
    assign sch_if.sch_err         = err_q;
endmodule

// File: tb/tb_enc_lane_scheduler.sv
// Directed bench for enc_lane_scheduler: three instances cover the
// default configuration, a 48-lane configuration and a 2-bit codeword
// counter.
module tb_enc_lane_scheduler;
    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic rst_c = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    enc_lane_scheduler_if #(.RS_COD_LEN(544), .ENC_SYM_NUM(32), .CW_CNT_W(16)) if_a ();
    enc_lane_scheduler_if #(.RS_COD_LEN(544), .ENC_SYM_NUM(48), .CW_CNT_W(16)) if_b ();
    enc_lane_scheduler_if #(.RS_COD_LEN(544), .ENC_SYM_NUM(32), .CW_CNT_W(2))  if_c ();

    enc_lane_scheduler #(.RS_COD_LEN(544), .RS_MSG_LEN(514), .ENC_SYM_NUM(32), .CW_CNT_W(16))
        u_dut_a (.clk(clk), .rst_n(rst_a), .sch_if(if_a.slave));
    enc_lane_scheduler #(.RS_COD_LEN(544), .RS_MSG_LEN(514), .ENC_SYM_NUM(48), .CW_CNT_W(16))
        u_dut_b (.clk(clk), .rst_n(rst_b), .sch_if(if_b.slave));
    enc_lane_scheduler #(.RS_COD_LEN(544), .RS_MSG_LEN(514), .ENC_SYM_NUM(32), .CW_CNT_W(2))
        u_dut_c (.clk(clk), .rst_n(rst_c), .sch_if(if_c.slave));

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic vld, input logic [63:0] par,
                           input logic [63:0] sop, input logic [63:0] eop,
                           input logic [63:0] cnt, input logic err);
        check_val({tag, "_valid"},  {63'd0, if_a.sch_valid}, {63'd0, vld});
        check_val({tag, "_parity"}, {32'd0, if_a.sch_parity_mask}, par);
        check_val({tag, "_sop"},    {32'd0, if_a.sch_sop_mask}, sop);
        check_val({tag, "_eop"},    {32'd0, if_a.sch_eop_mask}, eop);
        check_val({tag, "_cnt"},    {48'd0, if_a.sch_cw_done_cnt}, cnt);
        check_val({tag, "_err"},    {63'd0, if_a.sch_err}, {63'd0, err});
    endtask

    logic [1:0] exp_c [5];
    int         c_val;
    int         n_cw;
    logic       prev_eop_in;

    initial begin
        exp_c[0] = 2'd1; exp_c[1] = 2'd2; exp_c[2] = 2'd3; exp_c[3] = 2'd0; exp_c[4] = 2'd1;

        if_a.con_master_counter = '0;
        if_b.con_master_counter = '0;
        if_c.con_master_counter = '0;

        // reset state
        step();
        check_a("a_rst", 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);

        // full legal codeword 0..544
        rst_a = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            if_a.con_master_counter = 10'(k * 32);
            step();
            check_a("a_run", 1'b1,
                    (k == 16) ? 64'hFFFF_FFFC : 64'd0,
                    (k == 0 || k == 17) ? 64'd1 : 64'd0,
                    (k == 16) ? 64'h8000_0000 : 64'd0,
                    (k == 17) ? 64'd1 : 64'd0,
                    1'b0);
        end
        // 32..256 legal continuation
        for (int k = 1; k <= 8; k++) begin
            if_a.con_master_counter = 10'(k * 32);
            step();
            check_val("a_cont_err", {63'd0, if_a.sch_err}, 64'd0);
        end
        check_val("a_cont_cnt", {48'd0, if_a.sch_cw_done_cnt}, 64'd1);

        // reset mid-codeword at c=256
        rst_a = 1'b0;
        if_a.con_master_counter = 10'd256;
        step();
        check_a("a_midrst", 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        rst_a = 1'b1;
        if_a.con_master_counter = 10'd0;
        step();
        check_a("a_restart", 1'b1, 64'd0, 64'd1, 64'd0, 64'd0, 1'b0);
        if_a.con_master_counter = 10'd32;
        step();
        check_val("a_restart32_err", {63'd0, if_a.sch_err}, 64'd0);

        // skip: 96 where 64 is expected
        if_a.con_master_counter = 10'd96;
        step();
        check_a("a_skip", 1'b1, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
        if_a.con_master_counter = 10'd128;
        step();
        check_val("a_sticky1", {63'd0, if_a.sch_err}, 64'd1);
        if_a.con_master_counter = 10'd160;
        step();
        check_val("a_sticky2", {63'd0, if_a.sch_err}, 64'd1);
        rst_a = 1'b0;
        step();
        check_val("a_err_clr", {63'd0, if_a.sch_err}, 64'd0);

        // out-of-range 600 as first post-reset value
        rst_a = 1'b1;
        if_a.con_master_counter = 10'd600;
        step();
        check_a("a_oor", 1'b1, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
        rst_a = 1'b0;
        step();

        // 48 lanes: 480 -> 528 -> 32
        step();
        check_val("b_rst_valid", {63'd0, if_b.sch_valid}, 64'd0);
        rst_b = 1'b1;
        if_b.con_master_counter = 10'd480;
        step();
        check_val("b480_parity", {16'd0, if_b.sch_parity_mask}, 64'h0000_FFFC_0000_0000);
        check_val("b480_sop",    {16'd0, if_b.sch_sop_mask},    64'd0);
        check_val("b480_eop",    {16'd0, if_b.sch_eop_mask},    64'd0);
        if_b.con_master_counter = 10'd528;
        step();
        check_val("b528_parity", {16'd0, if_b.sch_parity_mask}, 64'h0000_0000_0000_FFFF);
        check_val("b528_eop",    {16'd0, if_b.sch_eop_mask},    64'h0000_0000_0000_8000);
        check_val("b528_sop",    {16'd0, if_b.sch_sop_mask},    64'h0000_0000_0001_0000);
        check_val("b528_err",    {63'd0, if_b.sch_err},         64'd0);
        if_b.con_master_counter = 10'd32;
        step();
        check_val("b32_err", {63'd0, if_b.sch_err},            64'd0);
        check_val("b32_cnt", {48'd0, if_b.sch_cw_done_cnt},    64'd1);
        check_val("b32_sop", {16'd0, if_b.sch_sop_mask},       64'd0);

        // 2-bit codeword counter over five codewords
        rst_c = 1'b1;
        c_val = 0;
        n_cw = 0;
        prev_eop_in = 1'b0;
        for (int i = 0; i < 200 && n_cw < 5; i++) begin
            if_c.con_master_counter = 10'(c_val);
            step();
            if (prev_eop_in) begin
                check_val($sformatf("c_cnt%0d", n_cw), {62'd0, if_c.sch_cw_done_cnt}, {62'd0, exp_c[n_cw]});
                n_cw++;
            end
            prev_eop_in = (c_val == 512);
            c_val = (c_val + 32 > 544) ? c_val + 32 - 544 : c_val + 32;
        end
        check_val("c_cw_seen", 64'(n_cw), 64'd5);
        check_val("c_err", {63'd0, if_c.sch_err}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/enc_lane_scheduler.md
Name: enc_lane_scheduler

Overview:
- Downstream consumer of the encoder master counter: once per cycle, classifies each of the ENC_SYM_NUM symbol lanes by codeword position.
- Produces registered per-lane masks (parity, start-of-codeword, end-of-codeword), a completed-codeword count and a sticky sequencing-error flag.
- Feeds the parity-insertion mux and the output framer, so neither needs its own position arithmetic.

Parameters:
- RS_COD_LEN, 544, codeword length in symbols.
- RS_MSG_LEN, 514, message symbols per codeword; positions >= RS_MSG_LEN are parity; must be < RS_COD_LEN.
- ENC_SYM_NUM, 32, symbols per cycle (lanes); 1 <= ENC_SYM_NUM <= RS_COD_LEN.
- CW_CNT_W, 16, width of the completed-codeword counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- con_master_counter  input  $clog2(RS_COD_LEN)  master counter value for the current cycle; legal range 0..RS_COD_LEN.
- sch_valid  output  1  high when the mask outputs describe a real cycle.
- sch_parity_mask  output  ENC_SYM_NUM  bit j = lane j carries a parity position.
- sch_sop_mask  output  ENC_SYM_NUM  bit j = lane j carries position 0.
- sch_eop_mask  output  ENC_SYM_NUM  bit j = lane j carries position RS_COD_LEN-1.
- sch_cw_done_cnt  output  CW_CNT_W  number of completed codewords, modulo 2^CW_CNT_W.
- sch_err  output  1  sticky counter-sequencing error.

Behaviour:
- Reset: the clock and reset are clk and rst_n (synchronous, active-low), as already decided. While rst_n is low at a clock edge, all outputs clear to 0 and the internal prev-valid flag clears.
- Lane position, for input c:
  - p_j = c + j, computed at width CNT_W+1 (CNT_W = $clog2(RS_COD_LEN)).
  - If p_j >= RS_COD_LEN, then p_j = p_j - RS_COD_LEN.
  - c == RS_COD_LEN is therefore equivalent to 0.
  - ENC_SYM_NUM <= RS_COD_LEN guarantees at most one wrap per cycle.
- Mask bits (combinational from p_j):
  - parity bit j = (p_j >= RS_MSG_LEN).
  - sop bit j = (p_j == 0).
  - eop bit j = (p_j == RS_COD_LEN-1).
- Latency: masks and sch_valid are registered, one cycle after the counter value they describe.
- sch_valid: 0 on reset; 1 from the first clock edge with rst_n high, and held there.
- sch_cw_done_cnt: increments by 1 on the edge where the registered eop mask becomes non-zero (at most one eop per cycle). Wraps from 2^CW_CNT_W-1 to 0.
- Sequence check:
  - The block stores the previous input c_prev and the prev-valid flag.
  - Expected value: if c_prev + ENC_SYM_NUM > RS_COD_LEN, then c_prev + ENC_SYM_NUM - RS_COD_LEN; else c_prev + ENC_SYM_NUM.
  - When prev-valid = 1 and the input differs from expected, sch_err sets on the next edge.
  - sch_err also sets when input > RS_COD_LEN, regardless of prev-valid.
  - No check is made in the first cycle after reset release.
  - sch_err stays high until reset; masks keep being computed from the input as given.
  - An out-of-range input yields the masks its wrapped arithmetic implies. It is not clamped.
- Reset mid-operation: outputs clear on that edge. The sequence restarts with prev-valid = 0, so a counter restart to 0 raises no error.
- No flow control: the block advances every cycle.

Test Plan:
- Reset, then counter 0,32,...,544 with defaults:
  - the cycle after c=0 shows sop_mask=0x00000001 and valid=1;
  - at c=512, parity_mask=0xFFFFFFFC and eop_mask=0x80000000;
  - cw_done_cnt goes 0 -> 1 one edge after the eop output;
  - at c=544, sop_mask=0x00000001 and parity_mask=0.
- ENC_SYM_NUM=48, counter steps 480 then 528:
  - c=480 -> parity lanes 34..47 set;
  - c=528 -> parity_mask=0x00000000FFFF, eop_mask bit 15, sop_mask bit 16;
  - the next counter value is 32, with no error.
- Inject 96 after 32 (expected 64): sch_err=1 one cycle later and stays 1 through further legal values; it clears only by reset.
- Inject 600 (> 544) as the first post-reset value: sch_err sets with no prev-valid. Masks follow the wrapped positions (56+j for 600+j >= 544), so sop_mask=0 and eop_mask=0.
- Assert rst_n low mid-codeword at c=256, release, and counter restarts at 0: outputs 0 during reset; sch_err stays 0; cw_done_cnt restarts from 0.
- CW_CNT_W=2, run 5 codewords: cw_done_cnt reads 1,2,3,0,1.
